sirv_uartrx_cfg: RTL and testbench

//  Parametrised UART receiver for the sirv peripheral set; successor to the fixed 8N1 receiver.

---
 rtl/sirv_uart_pkg.sv | 27 ++
 rtl/sirv_uart_sampler.sv | 49 ++++
 rtl/sirv_uartrx_cfg.sv | 185 ++++++++++++++++++
 tb/tb_sirv_uartrx_cfg.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sirv_uart_pkg.sv
// Shared UART definitions for the sirv parametrised receiver and the planned transmitter.
package sirv_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_OFF  = 2'b11
  } parity_e;

  localparam int unsigned DEF_OVS_LOG2 = 4;
  localparam int unsigned MIN_NBITS    = 5;

  // Two-of-three vote over the sample window.
  function automatic logic maj3(input logic [2:0] w);
    return (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
  endfunction

endpackage

// File: rtl/sirv_uart_sampler.sv
// Oversample prescaler, 3-sample majority window and per-bit timer for the UART receiver.
module sirv_uart_sampler
  import sirv_uart_pkg::*;
#(
  parameter int unsigned OVS_LOG2 = DEF_OVS_LOG2,
  parameter int unsigned PW       = 16 - OVS_LOG2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rx_i,
  input  logic [PW-1:0] div_i,
  input  logic          active_i,
  input  logic          start_i,
  output logic          bit_c_o,
  output logic          expire_c_o
);

  logic [PW-1:0]       pre_q;
  logic [PW-1:0]       reload_c;
  logic [OVS_LOG2-1:0] tmr_q;
  logic [2:0]          win_q;
  logic                tick_c;

  // Loading reload-1 gives a tick period of div clocks, so io_div reads as clocks per bit;
  // a zero reload saturates to a tick every clock.
  assign reload_c   = (div_i == '0) ? '0 : div_i - PW'(1);
  assign tick_c     = active_i & (pre_q == '0);
  assign expire_c_o = tick_c & (tmr_q == '0);
  assign bit_c_o    = maj3(win_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      tmr_q <= '0;
      win_q <= 3'b111;
    end else if (start_i) begin
      pre_q <= reload_c;
      tmr_q <= OVS_LOG2'(1 << (OVS_LOG2 - 1));
      win_q <= 3'b000;
    end else if (tick_c) begin
      pre_q <= reload_c;
      win_q <= {win_q[1:0], rx_i};
      tmr_q <= (tmr_q == '0) ? '1 : tmr_q - OVS_LOG2'(1);
    end else if (pre_q != '0) begin
      pre_q <= pre_q - PW'(1);
    end
  end

endmodule

// File: rtl/sirv_uartrx_cfg.sv
// Configurable UART receiver: 5..DATA_W data bits, 1/2 stop bits, framing error detection.
// Optional parity checking is built in when SIRV_UARTRX_PARITY_EN is defined.
module sirv_uartrx_cfg
  import sirv_uart_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned OVS_LOG2 = DEF_OVS_LOG2,
  parameter int unsigned DEB_W    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_en,
  input  logic              io_in,
  input  logic [15:0]       io_div,
  input  logic [3:0]        io_nbits,
  input  logic              io_nstop,
  input  logic [1:0]        io_parity,
  output logic              io_out_valid,
  output logic [DATA_W-1:0] io_out_bits,
  output logic              io_out_ferr,
  output logic              io_out_perr
);

  localparam int unsigned      CW      = $clog2(DATA_W + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = '1;
  localparam logic [DEB_W-1:0] DEB_ARM = DEB_MAX - DEB_W'(1);

  uart_state_e       state_q;
  logic [DEB_W-1:0]  deb_q;
  logic              brk_q;
  logic [CW-1:0]     nbits_q;
  logic [CW-1:0]     bitcnt_q;
  logic              nstop_q;
  logic              stop2_q;
  logic [DATA_W-1:0] shift_q;
  logic              ferr_acc_q;
  logic              valid_q;
  logic [DATA_W-1:0] bits_q;
  logic              ferr_q;

  logic              samp_bit_c;
  logic              expire_c;
  logic              start_c;
  logic              stop_bad_c;
  logic [CW-1:0]     nbits_c;
  uart_state_e       after_data_c;
  logic              unused_c;

`ifdef SIRV_UARTRX_PARITY_EN
  parity_e par_q;
  logic    perr_acc_q;
  logic    perr_q;

  assign after_data_c = (par_q == PAR_EVEN || par_q == PAR_ODD) ? ST_PARITY : ST_STOP;
  assign io_out_perr  = perr_q;
  assign unused_c     = ^io_div[OVS_LOG2-1:0];
`else
  assign after_data_c = ST_STOP;
  assign io_out_perr  = 1'b0;
  assign unused_c     = ^{io_div[OVS_LOG2-1:0], io_parity};
`endif

  sirv_uart_sampler #(
    .OVS_LOG2 (OVS_LOG2)
  ) u_sampler (
    .clock      (clock),
    .reset      (reset),
    .rx_i       (io_in),
    .div_i      (io_div[15:OVS_LOG2]),
    .active_i   (state_q != ST_IDLE),
    .start_i    (start_c),
    .bit_c_o    (samp_bit_c),
    .expire_c_o (expire_c)
  );

  always_comb begin
    nbits_c = CW'(DATA_W);
    if (32'(io_nbits) >= MIN_NBITS && 32'(io_nbits) <= DATA_W) nbits_c = CW'(io_nbits);
  end

  // brk_q blocks a restart until a low line held through stop has gone high long enough to drain.
  assign start_c    = (state_q == ST_IDLE) & io_en & ~io_in & ~brk_q & (deb_q == DEB_ARM);
  assign stop_bad_c = ferr_acc_q | ~samp_bit_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      deb_q      <= '0;
      brk_q      <= 1'b0;
      nbits_q    <= '0;
      bitcnt_q   <= '0;
      nstop_q    <= 1'b0;
      stop2_q    <= 1'b0;
      shift_q    <= '0;
      ferr_acc_q <= 1'b0;
      valid_q    <= 1'b0;
      bits_q     <= '0;
      ferr_q     <= 1'b0;
`ifdef SIRV_UARTRX_PARITY_EN
      par_q      <= PAR_NONE;
      perr_acc_q <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (!io_en) begin
        state_q <= ST_IDLE;
        deb_q   <= '0;
        brk_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_c) begin
              state_q    <= ST_START;
              deb_q      <= '0;
              nbits_q    <= nbits_c;
              nstop_q    <= io_nstop;
              stop2_q    <= 1'b0;
              shift_q    <= '0;
              ferr_acc_q <= 1'b0;
`ifdef SIRV_UARTRX_PARITY_EN
              par_q      <= parity_e'(io_parity);
              perr_acc_q <= 1'b0;
`endif
            end else if (!io_in) begin
              if (deb_q != DEB_MAX) deb_q <= deb_q + DEB_W'(1);
            end else if (deb_q != '0) begin
              deb_q <= deb_q - DEB_W'(1);
            end else begin
              brk_q <= 1'b0;
            end
          end
          ST_START: begin
            if (expire_c) begin
              state_q  <= samp_bit_c ? ST_IDLE : ST_DATA;
              bitcnt_q <= nbits_q;
            end
          end
          ST_DATA: begin
            if (expire_c) begin
              shift_q  <= {samp_bit_c, shift_q[DATA_W-1:1]};
              bitcnt_q <= bitcnt_q - CW'(1);
              if (bitcnt_q == CW'(1)) state_q <= after_data_c;
            end
          end
`ifdef SIRV_UARTRX_PARITY_EN
          ST_PARITY: begin
            // Unshifted upper bits are zero, so the shifter XOR equals the data XOR.
            if (expire_c) begin
              perr_acc_q <= samp_bit_c ^ (^shift_q) ^ (par_q == PAR_ODD);
              state_q    <= ST_STOP;
            end
          end
`endif
          ST_STOP: begin
            if (expire_c) begin
              if (nstop_q && !stop2_q) begin
                stop2_q    <= 1'b1;
                ferr_acc_q <= stop_bad_c;
              end else begin
                state_q <= ST_IDLE;
                valid_q <= 1'b1;
                bits_q  <= shift_q >> (DATA_W - 32'(nbits_q));
                ferr_q  <= stop_bad_c;
`ifdef SIRV_UARTRX_PARITY_EN
                perr_q  <= perr_acc_q;
`endif
                if (!samp_bit_c) begin
                  deb_q <= DEB_MAX;
                  brk_q <= 1'b1;
                end
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign io_out_valid = valid_q;
  assign io_out_bits  = bits_q;
  assign io_out_ferr  = ferr_q;

endmodule

// File: tb/tb_sirv_uartrx_cfg.sv
// Directed self-checking bench for sirv_uartrx_cfg at io_div=16 (16 clocks per bit).
module tb_sirv_uartrx_cfg;
  import sirv_uart_pkg::*;

  localparam int unsigned BP = 16;

  logic        clock;
  logic        reset;
  logic        io_en;
  logic        io_in;
  logic [15:0] io_div;
  logic [3:0]  io_nbits;
  logic        io_nstop;
  logic [1:0]  io_parity;
  logic        io_out_valid;
  logic [7:0]  io_out_bits;
  logic        io_out_ferr;
  logic        io_out_perr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vcnt = 0;
  int vcyc = 0;
  int scnt = 0;
  uart_state_e prev_st;

  sirv_uartrx_cfg #(.DATA_W(8), .OVS_LOG2(4), .DEB_W(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_en        (io_en),
    .io_in        (io_in),
    .io_div       (io_div),
    .io_nbits     (io_nbits),
    .io_nstop     (io_nstop),
    .io_parity    (io_parity),
    .io_out_valid (io_out_valid),
    .io_out_bits  (io_out_bits),
    .io_out_ferr  (io_out_ferr),
    .io_out_perr  (io_out_perr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Observation only: count valid strobes and entries into START.
  always @(negedge clock) begin
    if (io_out_valid) begin
      vcnt <= vcnt + 1;
      vcyc <= cyc;
    end
    if (dut.state_q == ST_START && prev_st != ST_START) scnt <= scnt + 1;
    prev_st <= dut.state_q;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v);
    io_in = v;
    repeat (BP) @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    io_in = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input int par,
                            input logic s1, input int ns, input logic s2);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (par >= 0) drive_bit(par[0]);
    drive_bit(s1);
    if (ns == 2) drive_bit(s2);
    io_in = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if (io_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", io_out_valid); end
    checks++;
    if (io_out_bits !== 8'h00) begin failures++; $display("FAIL reset_bits got=%h exp=00", io_out_bits); end
    checks++;
    if (io_out_ferr !== 1'b0 || io_out_perr !== 1'b0) begin
      failures++; $display("FAIL reset_err got=%b%b exp=00", io_out_ferr, io_out_perr);
    end
    checks++;
    if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_8n1();
    int v0, st, lat;
    v0 = vcnt;
    st = cyc;
    send_frame(8'hA5, 8, -1, 1'b1, 1, 1'b1);
    idle(2 * BP);
    lat = vcyc - st;
    checks++;
    if (vcnt !== v0 + 1) begin failures++; $display("FAIL 8n1_count got=%0d exp=%0d", vcnt - v0, 1); end
    checks++;
    if (io_out_bits !== 8'hA5) begin failures++; $display("FAIL 8n1_bits got=%h exp=a5", io_out_bits); end
    checks++;
    if (io_out_ferr !== 1'b0 || io_out_perr !== 1'b0) begin
      failures++; $display("FAIL 8n1_err got=%b%b exp=00", io_out_ferr, io_out_perr);
    end
    checks++;
    if (lat < 144 || lat > 176) begin failures++; $display("FAIL 8n1_latency got=%0d exp=144..176", lat); end
    idle(3 * BP);
    checks++;
    if (io_out_bits !== 8'hA5 || io_out_valid !== 1'b0) begin
      failures++; $display("FAIL 8n1_hold got=%h/%b exp=a5/0", io_out_bits, io_out_valid);
    end
  endtask

  task automatic test_5bit();
    int v0;
    v0 = vcnt;
    io_nbits = 4'd5;
    send_frame(8'h13, 5, -1, 1'b1, 1, 1'b1);
    idle(2 * BP);
    io_nbits = 4'd8;
    checks++;
    if (vcnt !== v0 + 1) begin failures++; $display("FAIL 5bit_count got=%0d exp=%0d", vcnt - v0, 1); end
    checks++;
    if (io_out_bits !== 8'h13 || io_out_ferr !== 1'b0) begin
      failures++; $display("FAIL 5bit_bits got=%h/%b exp=13/0", io_out_bits, io_out_ferr);
    end
  endtask

  task automatic test_clamp();
    int v0;
    v0 = vcnt;
    io_nbits = 4'd0;
    send_frame(8'hC3, 8, -1, 1'b1, 1, 1'b1);
    idle(2 * BP);
    io_nbits = 4'd8;
    checks++;
    if (vcnt !== v0 + 1 || io_out_bits !== 8'hC3) begin
      failures++; $display("FAIL clamp_bits got=%h cnt=%0d exp=c3 cnt=1", io_out_bits, vcnt - v0);
    end
  endtask

  task automatic test_2stop();
    int v0;
    v0 = vcnt;
    io_nstop = 1'b1;
    send_frame(8'h96, 8, -1, 1'b1, 2, 1'b1);
    idle(2 * BP);
    checks++;
    if (vcnt !== v0 + 1 || io_out_bits !== 8'h96 || io_out_ferr !== 1'b0) begin
      failures++; $display("FAIL 2stop_ok got=%h/%b cnt=%0d exp=96/0 cnt=1", io_out_bits, io_out_ferr, vcnt - v0);
    end
    v0 = vcnt;
    send_frame(8'h5A, 8, -1, 1'b1, 2, 1'b0);
    idle(2 * BP);
    io_nstop = 1'b0;
    checks++;
    if (vcnt !== v0 + 1) begin failures++; $display("FAIL 2stop_count got=%0d exp=1", vcnt - v0); end
    checks++;
    if (io_out_bits !== 8'h5A || io_out_ferr !== 1'b1) begin
      failures++; $display("FAIL 2stop_ferr got=%h/%b exp=5a/1", io_out_bits, io_out_ferr);
    end
  endtask

  task automatic test_glitch();
    int v0, s0;
    v0 = vcnt;
    s0 = scnt;
    io_in = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    idle(40);
    checks++;
    if (scnt !== s0) begin failures++; $display("FAIL glitch2_start got=%0d exp=0", scnt - s0); end
    io_in = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    idle(60);
    checks++;
    if (scnt !== s0 + 1) begin failures++; $display("FAIL glitch5_start got=%0d exp=1", scnt - s0); end
    checks++;
    if (vcnt !== v0 || dut.state_q !== ST_IDLE) begin
      failures++; $display("FAIL glitch5_novalid got=%0d st=%0d exp=0 st=%0d", vcnt - v0, dut.state_q, ST_IDLE);
    end
  endtask

  task automatic test_break();
    int v0, s0;
    v0 = vcnt;
    s0 = scnt;
    io_in = 1'b0;
    repeat (11 * BP) @(posedge clock);
    #1;
    idle(3 * BP);
    checks++;
    if (vcnt !== v0 + 1 || io_out_bits !== 8'h00 || io_out_ferr !== 1'b1) begin
      failures++; $display("FAIL break_frame got=%h/%b cnt=%0d exp=00/1 cnt=1", io_out_bits, io_out_ferr, vcnt - v0);
    end
    checks++;
    if (scnt !== s0 + 1) begin failures++; $display("FAIL break_restart got=%0d exp=1", scnt - s0); end
    send_frame(8'h81, 8, -1, 1'b1, 1, 1'b1);
    idle(2 * BP);
    checks++;
    if (vcnt !== v0 + 2 || io_out_bits !== 8'h81 || io_out_ferr !== 1'b0) begin
      failures++; $display("FAIL break_recover got=%h/%b cnt=%0d exp=81/0 cnt=2", io_out_bits, io_out_ferr, vcnt - v0);
    end
  endtask

  task automatic test_abort();
    int v0;
    logic [7:0] junk;
    junk = 8'b0110_1011;
    v0 = vcnt;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(junk[i]);
    io_en = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL abort_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
    for (int i = 3; i < 8; i++) drive_bit(junk[i]);
    drive_bit(1'b1);
    io_en = 1'b1;
    idle(2 * BP);
    checks++;
    if (vcnt !== v0) begin failures++; $display("FAIL abort_novalid got=%0d exp=0", vcnt - v0); end
    send_frame(8'h3C, 8, -1, 1'b1, 1, 1'b1);
    idle(2 * BP);
    checks++;
    if (vcnt !== v0 + 1 || io_out_bits !== 8'h3C || io_out_ferr !== 1'b0) begin
      failures++; $display("FAIL abort_next got=%h/%b cnt=%0d exp=3c/0 cnt=1", io_out_bits, io_out_ferr, vcnt - v0);
    end
  endtask

`ifdef SIRV_UARTRX_PARITY_EN
  task automatic test_parity();
    // 0x07 has three ones: odd parity expects parity bit 0, even parity expects 1.
    io_parity = 2'b10;
    send_frame(8'h07, 8, 0, 1'b1, 1, 1'b1);
    idle(2 * BP);
    checks++;
    if (io_out_bits !== 8'h07 || io_out_perr !== 1'b0) begin
      failures++; $display("FAIL par_odd0 got=%h/%b exp=07/0", io_out_bits, io_out_perr);
    end
    send_frame(8'h07, 8, 1, 1'b1, 1, 1'b1);
    idle(2 * BP);
    checks++;
    if (io_out_perr !== 1'b1) begin failures++; $display("FAIL par_odd1 got=%b exp=1", io_out_perr); end
    io_parity = 2'b01;
    send_frame(8'h07, 8, 1, 1'b1, 1, 1'b1);
    idle(2 * BP);
    checks++;
    if (io_out_perr !== 1'b0 || io_out_ferr !== 1'b0) begin
      failures++; $display("FAIL par_even1 got=%b/%b exp=0/0", io_out_perr, io_out_ferr);
    end
    io_parity = 2'b00;
  endtask
`endif

  initial begin
    reset     = 1'b1;
    io_en     = 1'b1;
    io_in     = 1'b1;
    io_div    = 16'd16;
    io_nbits  = 4'd8;
    io_nstop  = 1'b0;
    io_parity = 2'b00;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    idle(10);
    test_8n1();
    test_5bit();
    test_clamp();
    test_2stop();
    test_glitch();
    test_break();
    test_abort();
`ifdef SIRV_UARTRX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
